// File: rtl/spi_hsk_pkg.sv
// Shared types, defaults and parameter checks for the APB/SPI handshake synchroniser.
// SPI_HSK_TIMEOUT_EN enables the per-channel wait timeout.
package spi_hsk_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        REL,
        DONE,
        ERR
    } hsk_state_t;

    localparam int DEF_NCH         = 4;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_TIMEOUT     = 255;

`ifdef SPI_HSK_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    function automatic bit sync_ok(int ss);
        return ss >= 2;
    endfunction

    // A timeout shorter than one full loopback round trip would abort good handshakes.
    function automatic bit timeout_ok(int ss, int to, bit en);
        return !en || (to >= 2 * ss + 4);
    endfunction

endpackage

// File: rtl/spi_hsk_sync_mc_if.sv
// Per-channel request/acknowledge bundle between APB side, synchroniser and SPI engine.
// Bit i of every vector belongs to channel i.
interface spi_hsk_sync_mc_if #(
    parameter int NCH = 4
);
    logic [NCH-1:0] penable;
    logic [NCH-1:0] pready;
    logic [NCH-1:0] perror;
    logic [NCH-1:0] busy;
    logic [NCH-1:0] spi_enable;
    logic [NCH-1:0] spi_ready;

    modport master (
        output penable,
        output spi_ready,
        input  pready,
        input  perror,
        input  busy,
        input  spi_enable
    );

    modport slave (
        input  penable,
        input  spi_ready,
        output pready,
        output perror,
        output busy,
        output spi_enable
    );
endinterface

// File: rtl/spi_hsk_chan.sv
// One four-phase handshake channel: spi_ready synchroniser, FSM, optional wait timeout.
// SPI_HSK_TIMEOUT_EN adds the counter, the ERR state and perror.
module spi_hsk_chan
    import spi_hsk_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
`ifdef SPI_HSK_TIMEOUT_EN
    ,
    parameter int TIMEOUT = DEF_TIMEOUT
`endif
) (
    input  logic pclk,
    input  logic preset,
    input  logic penable,
    input  logic spi_ready,
    output logic pready,
    output logic perror,
    output logic busy,
    output logic spi_enable
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   ack_s;
    logic                   expired;
    hsk_state_t             state;
    hsk_state_t             nxt;

    always_ff @(posedge pclk) begin
        if (preset) sync <= '0;
        else        sync <= {sync[SYNC_STAGES-2:0], spi_ready};
    end

    assign ack_s = sync[SYNC_STAGES-1];

`ifdef SPI_HSK_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    // Restarts on every state change, so each wait phase gets its own budget.
    always_ff @(posedge pclk) begin
        if (preset)                      cnt <= '0;
        else if (nxt != state)           cnt <= '0;
        else if (state inside {REQ, REL}) cnt <= cnt + 1'b1;
    end

    assign expired = (cnt == CW'(TIMEOUT));
`else
    assign expired = 1'b0;
`endif

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE: if (penable && !ack_s) nxt = REQ;
            REQ: begin
                if (expired)    nxt = ERR;
                else if (ack_s) nxt = REL;
            end
            REL: begin
                if (expired)     nxt = ERR;
                else if (!ack_s) nxt = DONE;
            end
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state      <= IDLE;
            spi_enable <= 1'b0;
            pready     <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= nxt;
            spi_enable <= (nxt == REQ);
            pready     <= (nxt == DONE) || (nxt == ERR);
            busy       <= (nxt != IDLE);
        end
    end

`ifdef SPI_HSK_TIMEOUT_EN
    always_ff @(posedge pclk) begin
        if (preset) perror <= 1'b0;
        else        perror <= (nxt == ERR);
    end
`else
    assign perror = 1'b0;
`endif

endmodule

// File: rtl/spi_hsk_sync_mc.sv
// NCH independent APB/SPI four-phase handshake synchronisers in the pclk domain.
// SPI_HSK_TIMEOUT_EN enables per-channel timeout aborts reported on perror.
module spi_hsk_sync_mc
    import spi_hsk_pkg::*;
#(
    parameter int NCH         = DEF_NCH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int TIMEOUT     = DEF_TIMEOUT
) (
    input logic            pclk,
    input logic            preset,
    spi_hsk_sync_mc_if.slave hsk
);

    if (NCH < 1) begin : g_bad_nch
        $error("spi_hsk_sync_mc: NCH must be at least 1");
    end

    if (!sync_ok(SYNC_STAGES)) begin : g_bad_sync
        $error("spi_hsk_sync_mc: SYNC_STAGES must be at least 2");
    end

    if (!timeout_ok(SYNC_STAGES, TIMEOUT, TIMEOUT_EN)) begin : g_bad_to
        $error("spi_hsk_sync_mc: TIMEOUT must be at least 2*SYNC_STAGES+4");
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        spi_hsk_chan #(
            .SYNC_STAGES(SYNC_STAGES)
`ifdef SPI_HSK_TIMEOUT_EN
            ,
            .TIMEOUT(TIMEOUT)
`endif
        ) u_chan (
            .pclk      (pclk),
            .preset    (preset),
            .penable   (hsk.penable[i]),
            .spi_ready (hsk.spi_ready[i]),
            .pready    (hsk.pready[i]),
            .perror    (hsk.perror[i]),
            .busy      (hsk.busy[i]),
            .spi_enable(hsk.spi_enable[i])
        );
    end

endmodule
